// File: rtl/tile_compute_mx.sv
// rtl/tile_compute_mx.sv - tile compute sequencer: K-segment load/run/drain of a PE array into the C buffer
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   start_tile, k_total, m_eff,    tile start and geometry; relu_en/shift are
//   n_eff, relu_en, shift, abort   latched at start, abort cancels the tile at once
//   load_req, k_eff, ld_done       A/B segment load handshake
//   pe_start, pe_acc_clr, pe_done  PE run handshake; accumulators cleared on the first segment only
//   pe_drain_req, pe_c_valid,      PE result drain stream (TILE_SIZE*TILE_SIZE words, row-major)
//   pe_c_data, pe_c_last
//   c_seg_words, c_fill_req,       C buffer producer port: m_eff*n_eff compact words
//   c_fill_busy, c_fill_we,
//   c_fill_addr, c_fill_wdata,
//   c_fill_done
//   busy, tile_done, cfg_err       status
module tile_compute_mx #(
    parameter int TILE_SIZE = 8,
    parameter int ACC_BITS  = 32,
    parameter int KDIM_BITS = 16,
    parameter int C_DEPTH   = TILE_SIZE * TILE_SIZE,
    parameter int CA_W      = $clog2(C_DEPTH),
    parameter int EFF_BITS  = $clog2(TILE_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_tile,
    input  logic [KDIM_BITS-1:0] k_total,
    input  logic [EFF_BITS-1:0]  m_eff,
    input  logic [EFF_BITS-1:0]  n_eff,
    input  logic                 relu_en,
    input  logic [4:0]           shift,
    input  logic                 abort,
    output logic                 load_req,
    output logic [EFF_BITS-1:0]  k_eff,
    input  logic                 ld_done,
    output logic                 pe_start,
    output logic                 pe_acc_clr,
    input  logic                 pe_done,
    output logic                 pe_drain_req,
    input  logic                 pe_c_valid,
    input  logic [ACC_BITS-1:0]  pe_c_data,
    input  logic                 pe_c_last,
    output logic [31:0]          c_seg_words,
    output logic                 c_fill_req,
    input  logic                 c_fill_busy,
    output logic                 c_fill_we,
    output logic [CA_W-1:0]      c_fill_addr,
    output logic [ACC_BITS-1:0]  c_fill_wdata,
    input  logic                 c_fill_done,
    output logic                 busy,
    output logic                 tile_done,
    output logic                 cfg_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_PREP, S_LOAD, S_RUN, S_WAIT, S_FREQ, S_DRAIN, S_ZFILL, S_FWAIT, S_DONE
    } state_t;

    localparam logic [EFF_BITS-1:0]  TS_E = EFF_BITS'(TILE_SIZE);
    localparam logic [KDIM_BITS-1:0] TS_K = KDIM_BITS'(TILE_SIZE);

    state_t                       state;
    logic [KDIM_BITS-1:0]         k_rem;
    logic [EFF_BITS-1:0]          m_r, n_r;
    logic [EFF_BITS-1:0]          row, col;
    logic                         relu_r;
    logic [4:0]                   shift_r;
    logic                         first_seg;     // still 1 at FREQ means no segment ran (k_total == 0)
    logic                         drain_first;
    logic                         done_sticky;   // c_fill_done seen before FWAIT
    logic [CA_W-1:0]              wr_ptr;
    logic [31:0]                  zcnt;
    logic [EFF_BITS-1:0]          seg_len;
    logic signed [ACC_BITS-1:0]   shifted;
    logic [ACC_BITS-1:0]          proc_data;
    logic                         start_ok;

    always_comb begin
        seg_len   = (k_rem >= TS_K) ? TS_E : k_rem[EFF_BITS-1:0];
        shifted   = $signed(pe_c_data) >>> shift_r;
        proc_data = (relu_r && shifted[ACC_BITS-1]) ? '0 : shifted;
        start_ok  = (m_eff != '0) && (m_eff <= TS_E) && (n_eff != '0) && (n_eff <= TS_E);
    end

    assign load_req     = (state == S_LOAD);
    assign k_eff        = load_req ? seg_len : '0;
    assign pe_start     = (state == S_RUN);
    assign pe_acc_clr   = pe_start && first_seg;
    assign pe_drain_req = (state == S_DRAIN) && drain_first;
    assign tile_done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            k_rem        <= '0;
            m_r          <= '0;
            n_r          <= '0;
            row          <= '0;
            col          <= '0;
            relu_r       <= 1'b0;
            shift_r      <= '0;
            first_seg    <= 1'b0;
            drain_first  <= 1'b0;
            done_sticky  <= 1'b0;
            wr_ptr       <= '0;
            zcnt         <= '0;
            c_seg_words  <= '0;
            c_fill_req   <= 1'b0;
            c_fill_we    <= 1'b0;
            c_fill_addr  <= '0;
            c_fill_wdata <= '0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            c_fill_req <= 1'b0;
            c_fill_we  <= 1'b0;
            cfg_err    <= 1'b0;
            if (abort) begin
                // c_seg_words is deliberately kept for the consumer side
                state       <= S_IDLE;
                busy        <= 1'b0;
                k_rem       <= '0;
                first_seg   <= 1'b0;
                drain_first <= 1'b0;
                done_sticky <= 1'b0;
                row         <= '0;
                col         <= '0;
                wr_ptr      <= '0;
                zcnt        <= '0;
            end else begin
                if (c_fill_done && (state == S_DRAIN || state == S_ZFILL))
                    done_sticky <= 1'b1;
                case (state)
                    S_IDLE: begin
                        if (start_tile) begin
                            if (start_ok) begin
                                k_rem       <= k_total;
                                m_r         <= m_eff;
                                n_r         <= n_eff;
                                relu_r      <= relu_en;
                                shift_r     <= shift;
                                first_seg   <= 1'b1;
                                c_seg_words <= 32'(m_eff) * 32'(n_eff);
                                busy        <= 1'b1;
                                state       <= S_PREP;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_PREP:  state <= (k_rem == '0) ? S_FREQ : S_LOAD;
                    S_LOAD:  if (ld_done) state <= S_RUN;
                    S_RUN:   state <= S_WAIT;
                    S_WAIT: begin
                        if (pe_done) begin
                            k_rem     <= k_rem - KDIM_BITS'(seg_len);
                            first_seg <= 1'b0;
                            state     <= (k_rem == KDIM_BITS'(seg_len)) ? S_FREQ : S_PREP;
                        end
                    end
                    S_FREQ: begin
                        if (!c_fill_busy) begin
                            c_fill_req <= 1'b1;
                            if (first_seg) begin
                                zcnt  <= '0;
                                state <= S_ZFILL;
                            end else begin
                                drain_first <= 1'b1;
                                row         <= '0;
                                col         <= '0;
                                wr_ptr      <= '0;
                                state       <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        drain_first <= 1'b0;
                        if (pe_c_valid) begin
                            // drain order is row-major over the full array; only the
                            // m x n corner is written, packed at consecutive addresses
                            if (row < m_r && col < n_r) begin
                                c_fill_we    <= 1'b1;
                                c_fill_addr  <= wr_ptr;
                                c_fill_wdata <= proc_data;
                                wr_ptr       <= wr_ptr + 1'b1;
                            end
                            if (col == TS_E - 1'b1) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            if (pe_c_last) state <= S_FWAIT;
                        end
                    end
                    S_ZFILL: begin
                        c_fill_we    <= 1'b1;
                        c_fill_addr  <= zcnt[CA_W-1:0];
                        c_fill_wdata <= '0;
                        zcnt         <= zcnt + 32'd1;
                        if (zcnt == c_seg_words - 32'd1) state <= S_FWAIT;
                    end
                    S_FWAIT: if (c_fill_done || done_sticky) state <= S_DONE;
                    S_DONE: begin
                        done_sticky <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tile_compute_mx.sv
// tb/tb_tile_compute_mx.sv - randomized scoreboard bench for tile_compute_mx
module tb_tile_compute_mx;
    localparam int T  = 8;
    localparam int CW = 6;

    logic        clk, rstn, start_tile;
    logic [15:0] k_total;
    logic [3:0]  m_eff, n_eff;
    logic        relu_en;
    logic [4:0]  shift;
    logic        abort;
    logic        load_req;
    logic [3:0]  k_eff;
    logic        ld_done, pe_start, pe_acc_clr, pe_done, pe_drain_req;
    logic        pe_c_valid;
    logic [31:0] pe_c_data;
    logic        pe_c_last;
    logic [31:0] c_seg_words;
    logic        c_fill_req, c_fill_busy, c_fill_we;
    logic [CW-1:0] c_fill_addr;
    logic [31:0] c_fill_wdata;
    logic        c_fill_done, busy, tile_done, cfg_err;

    tile_compute_mx #(.TILE_SIZE(T), .ACC_BITS(32), .KDIM_BITS(16)) dut (
        .clk(clk), .rstn(rstn), .start_tile(start_tile), .k_total(k_total),
        .m_eff(m_eff), .n_eff(n_eff), .relu_en(relu_en), .shift(shift), .abort(abort),
        .load_req(load_req), .k_eff(k_eff), .ld_done(ld_done),
        .pe_start(pe_start), .pe_acc_clr(pe_acc_clr), .pe_done(pe_done),
        .pe_drain_req(pe_drain_req), .pe_c_valid(pe_c_valid), .pe_c_data(pe_c_data),
        .pe_c_last(pe_c_last), .c_seg_words(c_seg_words), .c_fill_req(c_fill_req),
        .c_fill_busy(c_fill_busy), .c_fill_we(c_fill_we), .c_fill_addr(c_fill_addr),
        .c_fill_wdata(c_fill_wdata), .c_fill_done(c_fill_done), .busy(busy),
        .tile_done(tile_done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0, n_err = 0;
    logic [31:0] drain_data [64];
    logic [CW-1:0] exp_addr [$];
    logic [31:0]   exp_data [$];
    int keff_got [$];
    int cnt_start, cnt_clr, cnt_done, cnt_cfg, cnt_freq, cnt_drain, pe_done_cnt, fill_req_cyc;
    bit hold_pe = 0, drain_tile = 0, fill_seen = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] proc_ref(input logic [31:0] x, input int sh, input bit relu);
        longint v;
        v = longint'($signed(x));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        return v[31:0];
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (pe_start) cnt_start++;
            if (pe_start && pe_acc_clr) cnt_clr++;
            if (tile_done) cnt_done++;
            if (cfg_err) cnt_cfg++;
            if (pe_drain_req) cnt_drain++;
            if (c_fill_req) begin
                cnt_freq++;
                fill_req_cyc = cyc;
                fill_seen = 1;
            end
            if (!load_req) check("k_eff_idle", 64'(k_eff), 64'd0);
            if (c_fill_we) begin
                check("we_after_fill_req", 64'(fill_seen), 64'd1);
                if (drain_tile) check("we_latency", 64'(prev_valid), 64'd1);
                if (exp_addr.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected none", c_fill_addr, c_fill_wdata);
                end else begin
                    logic [CW-1:0] a;
                    logic [31:0] d;
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    check("wr_addr", 64'(c_fill_addr), 64'(a));
                    check("wr_data", 64'(c_fill_wdata), 64'(d));
                end
            end
            prev_valid = pe_c_valid;
        end
    end

    // loader model
    initial begin
        ld_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (load_req) begin
                keff_got.push_back(int'(k_eff));
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                ld_done = 1'b1;
                @(posedge clk); #1;
                ld_done = 1'b0;
            end
        end
    end

    // PE run model
    initial begin
        pe_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pe_start && !hold_pe) begin
                repeat (1 + $urandom_range(0, 3)) begin @(posedge clk); #1; end
                pe_done = 1'b1;
                @(posedge clk); #1;
                pe_done = 1'b0;
                pe_done_cnt++;
            end
        end
    end

    // PE drain model: full TxT row-major stream with random gaps
    initial begin
        pe_c_valid = 1'b0;
        pe_c_data  = '0;
        pe_c_last  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pe_drain_req) begin
                for (int i = 0; i < T * T; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    pe_c_valid = 1'b1;
                    pe_c_data  = drain_data[i];
                    pe_c_last  = (i == T * T - 1);
                    @(posedge clk); #1;
                    pe_c_valid = 1'b0;
                    pe_c_last  = 1'b0;
                end
            end
        end
    end

    // C buffer commit model: done may land early (during drain/zfill) or late
    initial begin
        c_fill_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (c_fill_req) begin
                repeat ($urandom_range(0, 80)) begin @(posedge clk); #1; end
                c_fill_done = 1'b1;
                @(posedge clk); #1;
                c_fill_done = 1'b0;
            end
        end
    end

    task automatic run_tile(input int k, input int m, input int n, input bit relu,
                            input int sh, input int mode, input int busy_hold);
        int segs, rem, drop_cyc;
        int keff_exp [$];
        bit got;
        segs = (k + T - 1) / T;
        for (int i = 0; i < T * T; i++)
            drain_data[i] = (mode == 1) ? 32'(i) : $urandom();
        if (mode == 2) begin
            drain_data[0] = 32'hFFFF_FF00;
            drain_data[1] = 32'h0000_0100;
        end
        if (k == 0) begin
            for (int a = 0; a < m * n; a++) begin
                exp_addr.push_back(CW'(a));
                exp_data.push_back(32'd0);
            end
        end else begin
            for (int r = 0; r < m; r++)
                for (int c = 0; c < n; c++) begin
                    exp_addr.push_back(CW'(r * n + c));
                    exp_data.push_back(proc_ref(drain_data[r * T + c], sh, relu));
                end
        end
        rem = k;
        while (rem > 0) begin
            keff_exp.push_back(rem > T ? T : rem);
            rem -= (rem > T ? T : rem);
        end
        cnt_start = 0; cnt_clr = 0; cnt_done = 0; cnt_freq = 0; cnt_drain = 0;
        pe_done_cnt = 0; fill_seen = 0; drain_tile = (k > 0);
        keff_got.delete();
        drop_cyc = 0;
        c_fill_busy = (busy_hold > 0);

        @(posedge clk); #1;
        start_tile = 1'b1; k_total = 16'(k); m_eff = 4'(m); n_eff = 4'(n);
        relu_en = relu; shift = 5'(sh);
        @(posedge clk); #1;
        start_tile = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);

        if (busy_hold > 0) begin
            got = 0;
            for (int i = 0; i < 500 && !got; i++) begin
                if (pe_done_cnt == segs) got = 1;
                else begin @(posedge clk); #1; end
            end
            check("busy_hold_reach_freq", 64'(got), 64'd1);
            repeat (busy_hold) begin @(posedge clk); #1; end
            check("no_fill_req_while_busy", 64'(cnt_freq), 64'd0);
            c_fill_busy = 1'b0;
            drop_cyc = cyc;
        end

        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (tile_done) got = 1;
        end
        check("tile_done_seen", 64'(got), 64'd1);
        if (!got) begin
            @(posedge clk); #1; abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
            exp_addr.delete();
            exp_data.delete();
        end
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("tile_done_count", 64'(cnt_done), 64'(got ? 1 : 0));
        check("pe_start_count", 64'(cnt_start), 64'(segs));
        check("acc_clr_count", 64'(cnt_clr), 64'(k > 0 ? 1 : 0));
        check("fill_req_count", 64'(cnt_freq), 64'd1);
        check("drain_req_count", 64'(cnt_drain), 64'(k > 0 ? 1 : 0));
        check("writes_outstanding", 64'(exp_addr.size()), 64'd0);
        check("c_seg_words", 64'(c_seg_words), 64'(m * n));
        check("keff_count", 64'(keff_got.size()), 64'(keff_exp.size()));
        for (int i = 0; i < keff_exp.size() && i < keff_got.size(); i++)
            check("keff_value", 64'(keff_got[i]), 64'(keff_exp[i]));
        if (busy_hold > 0) check("fill_req_after_busy_drop", 64'(fill_req_cyc - drop_cyc), 64'd1);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic bad_start(input int m, input int n);
        cnt_cfg = 0;
        @(posedge clk); #1;
        start_tile = 1'b1; m_eff = 4'(m); n_eff = 4'(n); k_total = 16'd8;
        @(posedge clk); #1;
        start_tile = 1'b0;
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_busy", 64'(busy), 64'd0);
        repeat (4) begin
            @(posedge clk); #1;
            check("cfg_err_busy_stays0", 64'(busy), 64'd0);
        end
        check("cfg_err_count", 64'(cnt_cfg), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rstn = 1'b0; start_tile = 1'b0; k_total = '0; m_eff = '0; n_eff = '0;
        relu_en = 1'b0; shift = '0; abort = 1'b0; c_fill_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_req", 64'(load_req), 64'd0);
        check("rst_k_eff", 64'(k_eff), 64'd0);
        check("rst_pe_start", 64'(pe_start), 64'd0);
        check("rst_pe_acc_clr", 64'(pe_acc_clr), 64'd0);
        check("rst_pe_drain_req", 64'(pe_drain_req), 64'd0);
        check("rst_c_seg_words", 64'(c_seg_words), 64'd0);
        check("rst_c_fill_req", 64'(c_fill_req), 64'd0);
        check("rst_c_fill_we", 64'(c_fill_we), 64'd0);
        check("rst_c_fill_addr", 64'(c_fill_addr), 64'd0);
        check("rst_c_fill_wdata", 64'(c_fill_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tile_done", 64'(tile_done), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rstn = 1'b1;

        run_tile(16, 8, 8, 0, 0, 0, 0);   // full tile, two segments
        run_tile(13, 8, 8, 0, 0, 0, 0);   // partial last segment: 8 then 5
        run_tile(8, 3, 5, 0, 0, 1, 0);    // masked compact drain of index data
        run_tile(8, 1, 2, 1, 4, 2, 0);    // shift + relu on 0xFFFFFF00 / 0x100
        run_tile(0, 2, 2, 0, 0, 0, 0);    // zero-fill path
        run_tile(8, 4, 4, 0, 0, 0, 5);    // c_fill_busy held in FREQ

        bad_start(0, 4);
        bad_start(4, 9);

        // abort while waiting on the PE
        hold_pe = 1; cnt_start = 0; cnt_done = 0; keff_got.delete();
        @(posedge clk); #1;
        start_tile = 1'b1; k_total = 16'd16; m_eff = 4'd8; n_eff = 4'd8;
        @(posedge clk); #1;
        start_tile = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (pe_start) got = 1;
        end
        check("abort_reached_run", 64'(got), 64'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_tile_done", 64'(cnt_done), 64'd0);
        check("abort_no_more_loads", 64'(keff_got.size()), 64'd1);
        check("abort_c_seg_words_kept", 64'(c_seg_words), 64'd64);
        hold_pe = 0;
        repeat (8) @(posedge clk);

        for (int t = 0; t < 8; t++)
            run_tile($urandom_range(0, 40), $urandom_range(1, T), $urandom_range(1, T),
                     1'($urandom_range(0, 1)), $urandom_range(0, 16), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
